proj_read_sched: RTL and testbench

- Sequencer in front of the minhash core (FM, counter, k-mer buffer, hasher, sorter, extender).
- Takes whole reads as a valid/ready base stream and issues the core's one-cycle start pulse.
- Feeds exactly READ_LEN bases, honouring the FM stall, then waits for the pipeline to flush.
- Buffers the NUM_FRAGS extended fragments per read and returns them on a valid/ready output stream with a last flag.

---
 rtl/proj_read_sched.sv | 185 ++++++++++++++++++
 tb/tb_proj_read_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/proj_read_sched.sv
// Read sequencer for the minhash core: feeds READ_LEN bases per read, pads or truncates
// malformed reads, waits for the pipeline to drain, then returns the read's fragments.
module proj_read_sched #(
  parameter int BASE_LEN     = 2,
  parameter int FRAG_LEN     = 64,
  parameter int READ_LEN     = 150,
  parameter int NUM_FRAGS    = 4,
  parameter int DRAIN_CYCLES = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BASE_LEN-1:0] s_base,
  input  logic                s_valid,
  input  logic                s_last,
  output logic                s_ready,
  output logic                core_start,
  output logic [BASE_LEN-1:0] core_data,
  input  logic                core_wait,
  input  logic [FRAG_LEN-1:0] core_frag,
  input  logic                core_frag_valid,
  output logic [FRAG_LEN-1:0] m_frag,
  output logic                m_valid,
  output logic                m_last,
  input  logic                m_ready,
  output logic                busy,
  output logic                err_len,
  output logic [15:0]         read_cnt
);

  localparam int BASE_CNT_W = $clog2(READ_LEN + 1);
  localparam int DRAIN_W    = $clog2(DRAIN_CYCLES + 1);
  localparam int FRAG_CNT_W = $clog2(NUM_FRAGS + 1);
  localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE, START, STREAM, PAD, DISCARD, DRAIN, COLLECT
  } state_t;

  typedef struct packed {
    logic                last;
    logic [FRAG_LEN-1:0] frag;
  } entry_t;

  state_t                 state;
  logic [BASE_CNT_W-1:0]  base_cnt;
  logic [DRAIN_W-1:0]     drain_cnt;
  logic [FRAG_CNT_W-1:0]  frag_cnt;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [OCC_W-1:0]       fifo_cnt;
  entry_t                 fifo_mem [FIFO_DEPTH];
  entry_t                 head;

  logic accept;
  logic capture;
  logic push;
  logic pop;
  logic at_last_base;
  logic read_done;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    s_ready = 1'b0;
    case (state)
      STREAM:  s_ready = !core_wait;
      DISCARD: s_ready = 1'b1;
      default: s_ready = 1'b0;
    endcase
  end

  assign accept       = s_valid && s_ready;
  assign at_last_base = (base_cnt == BASE_CNT_W'(READ_LEN - 1));
  assign capture      = core_frag_valid && (state == DRAIN || state == COLLECT);
  assign push         = capture && (frag_cnt < FRAG_CNT_W'(NUM_FRAGS));
  assign head         = fifo_mem[rd_ptr];
  assign m_valid      = (state == COLLECT) && (fifo_cnt != '0);
  assign pop          = m_valid && m_ready;
  assign read_done    = pop && head.last;
  // Gate the head so stale or uninitialised storage never reaches the output.
  assign m_frag       = m_valid ? head.frag : '0;
  assign m_last       = m_valid && head.last;
  assign busy         = (state != IDLE);

  // NOTE: the storage array has no reset; pointers and occupancy are reset, so it is never read unwritten.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {frag_cnt == FRAG_CNT_W'(NUM_FRAGS - 1), core_frag};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      core_start <= 1'b0;
      core_data  <= '0;
      err_len    <= 1'b0;
      read_cnt   <= '0;
      base_cnt   <= '0;
      drain_cnt  <= '0;
      frag_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
    end else begin
      core_start <= 1'b0;
      case (state)
        IDLE: begin
          if (s_valid) begin
            state      <= START;
            core_start <= 1'b1;
          end
        end
        START: state <= STREAM;
        STREAM: begin
          if (accept) begin
            core_data <= s_base;
            base_cnt  <= base_cnt + 1'b1;
            if (at_last_base) begin
              if (s_last) begin
                state <= DRAIN;
              end else begin
                err_len <= 1'b1;
                state   <= DISCARD;
              end
            end else if (s_last) begin
              err_len <= 1'b1;
              state   <= PAD;
            end
          end
        end
        PAD: begin
          if (!core_wait) begin
            core_data <= '0;
            base_cnt  <= base_cnt + 1'b1;
            if (at_last_base) state <= DRAIN;
          end
        end
        DISCARD: begin
          core_data <= '0;
          if (accept && s_last) state <= DRAIN;
        end
        DRAIN: begin
          core_data <= '0;
          if (!core_wait) begin
            if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
              drain_cnt <= '0;
              state     <= COLLECT;
            end else begin
              drain_cnt <= drain_cnt + 1'b1;
            end
          end
        end
        COLLECT: begin
          if (read_done) begin
            read_cnt <= read_cnt + 1'b1;
            base_cnt <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase

      // Extra fragments for a read are dropped and flagged; the count restarts with the next read.
      if (capture) begin
        if (push) frag_cnt <= frag_cnt + 1'b1;
        else      err_len  <= 1'b1;
      end
      if (state == COLLECT && read_done) frag_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_proj_read_sched.sv
// Directed bench for proj_read_sched: nominal, stalled, short, long, backpressured
// and reset-aborted reads, with a small in-bench core model supplying fragments.
module tb_proj_read_sched;

  localparam int BASE_LEN     = 2;
  localparam int FRAG_LEN     = 64;
  localparam int READ_LEN     = 150;
  localparam int NUM_FRAGS    = 4;
  localparam int DRAIN_CYCLES = 8;
  localparam int FIFO_DEPTH   = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [BASE_LEN-1:0] s_base;
  logic                s_valid;
  logic                s_last;
  logic                s_ready;
  logic                core_start;
  logic [BASE_LEN-1:0] core_data;
  logic                core_wait;
  logic [FRAG_LEN-1:0] core_frag;
  logic                core_frag_valid;
  logic [FRAG_LEN-1:0] m_frag;
  logic                m_valid;
  logic                m_last;
  logic                m_ready;
  logic                busy;
  logic                err_len;
  logic [15:0]         read_cnt;

  int checks   = 0;
  int failures = 0;
  logic [FRAG_LEN-1:0] frag_exp [NUM_FRAGS];

  proj_read_sched #(
    .BASE_LEN(BASE_LEN), .FRAG_LEN(FRAG_LEN), .READ_LEN(READ_LEN),
    .NUM_FRAGS(NUM_FRAGS), .DRAIN_CYCLES(DRAIN_CYCLES), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_base(s_base), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .core_start(core_start), .core_data(core_data), .core_wait(core_wait),
    .core_frag(core_frag), .core_frag_valid(core_frag_valid),
    .m_frag(m_frag), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
    .busy(busy), .err_len(err_len), .read_cnt(read_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BASE_LEN-1:0] base_of(input int i);
    return BASE_LEN'((i * 3 + 2) % 4);
  endfunction

  task automatic set_frags(input int read_id);
    for (int i = 0; i < NUM_FRAGS; i++)
      frag_exp[i] = 64'hF00D_0000_0000_0000 | (64'(read_id) << 16) | 64'(i + 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"},    s_ready,    0);
    check({tag, "_core_start"}, core_start, 0);
    check({tag, "_core_data"},  core_data,  0);
    check({tag, "_m_frag"},     m_frag,     0);
    check({tag, "_m_valid"},    m_valid,    0);
    check({tag, "_m_last"},     m_last,     0);
    check({tag, "_busy"},       busy,       0);
    check({tag, "_err_len"},    err_len,    0);
    check({tag, "_read_cnt"},   read_cnt,   0);
  endtask

  // Entered and left 1 time unit after a rising edge; on return the last beat was accepted on the previous edge.
  task automatic feed(input int n, input bit with_last, input int stall_at, input int stall_len,
                      input int exp_edges, input int exp_starts);
    int edges = 0;
    int starts = 0;
    int data_errs = 0;
    int stall_errs = 0;
    int guard;
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_base  = base_of(i);
      s_last  = with_last && (i == n - 1);
      if (i == stall_at) begin
        core_wait = 1'b1;
        for (int k = 0; k < stall_len; k++) begin
          #1;
          if (s_ready !== 1'b0) stall_errs++;
          @(posedge clk); edges++; #1;
          if (core_data !== base_of(i - 1)) stall_errs++;
        end
        core_wait = 1'b0;
      end
      #1;
      guard = 0;
      while (s_ready !== 1'b1 && guard < 100) begin
        if (core_start) starts++;
        @(posedge clk); edges++; #2;
        guard++;
      end
      if (guard >= 100) begin
        check("feed_accept_timeout", guard, 0);
        break;
      end
      if (core_start) starts++;
      @(posedge clk); edges++; #1;
      if (i < READ_LEN && core_data !== base_of(i)) data_errs++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("core_data_seq", data_errs, 0);
    if (stall_len > 0) check("stall_hold", stall_errs, 0);
    if (exp_edges >= 0) check("feed_cycles", edges, exp_edges);
    check("core_start_pulses", starts, exp_starts);
  endtask

  // Core model: fragments strobe from 'delay' cycles after the last accepted beat; an optional
  // junk strobe one cycle earlier must be ignored. Measures cycles until m_valid rises.
  task automatic run_core(input int delay, input bit junk, input int exp_lat);
    int lat = -1;
    m_ready = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (cyc == 1) check("drain_core_data_zero", core_data, 0);
      if (m_valid === 1'b1 && lat < 0) lat = cyc;
      if (lat >= 0 && cyc >= delay + NUM_FRAGS) break;
      if (junk && cyc == delay - 1) begin
        core_frag_valid = 1'b1;
        core_frag       = 64'hDEAD_BEEF_DEAD_BEEF;
      end else if (cyc >= delay && cyc < delay + NUM_FRAGS) begin
        core_frag_valid = 1'b1;
        core_frag       = frag_exp[cyc - delay];
      end else begin
        core_frag_valid = 1'b0;
        core_frag       = '0;
      end
      @(posedge clk); #1;
    end
    core_frag_valid = 1'b0;
    core_frag       = '0;
    check("collect_latency", lat, exp_lat);
  endtask

  task automatic collect(input int hold, input bit hold_svalid, input int exp_cnt);
    int hold_errs = 0;
    m_ready = 1'b0;
    if (hold_svalid) begin
      s_valid = 1'b1;
      s_base  = base_of(0);
      s_last  = 1'b0;
    end
    for (int h = 0; h < hold; h++) begin
      #1;
      if (m_valid !== 1'b1 || m_frag !== frag_exp[0] || m_last !== 1'b0) hold_errs++;
      if (s_ready !== 1'b0 || core_start !== 1'b0) hold_errs++;
      @(posedge clk); #1;
    end
    if (hold > 0) check("backpressure_hold", hold_errs, 0);
    for (int i = 0; i < NUM_FRAGS; i++) begin
      m_ready = 1'b1;
      #1;
      check($sformatf("m_frag_%0d", i), m_frag, frag_exp[i]);
      check($sformatf("m_valid_last_%0d", i), {m_valid, m_last}, {1'b1, i == NUM_FRAGS - 1});
      @(posedge clk); #1;
    end
    m_ready = 1'b0;
    check("read_cnt", read_cnt, exp_cnt);
    check("busy_after_read", busy, 0);
    if (hold_svalid) begin
      check("no_start_before_last_pop", core_start, 0);
      @(posedge clk); #1;
      check("start_after_last_pop", core_start, 1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    s_base = '0; s_valid = 1'b0; s_last = 1'b0;
    core_wait = 1'b0; core_frag = '0; core_frag_valid = 1'b0; m_ready = 1'b0;
    #2;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Nominal read
    set_frags(1);
    feed(READ_LEN, 1'b1, -1, 0, READ_LEN + 2, 1);
    run_core(0, 1'b0, DRAIN_CYCLES);
    collect(0, 1'b0, 1);
    check("err_len_nominal", err_len, 0);

    // Five-cycle core stall at base 40
    set_frags(2);
    feed(READ_LEN, 1'b1, 40, 5, READ_LEN + 2 + 5, 1);
    run_core(0, 1'b0, DRAIN_CYCLES);
    collect(0, 1'b0, 2);
    check("err_len_stall", err_len, 0);

    // Short read: 100 bases, 50 pad cycles before the drain starts
    set_frags(3);
    feed(100, 1'b1, -1, 0, 102, 1);
    check("err_len_short", err_len, 1);
    run_core(READ_LEN - 100, 1'b1, READ_LEN - 100 + DRAIN_CYCLES);
    collect(0, 1'b0, 3);

    // Long read: 160 bases, the last 10 discarded without stalling
    set_frags(4);
    feed(160, 1'b1, -1, 0, 162, 1);
    check("err_len_long", err_len, 1);
    run_core(0, 1'b0, DRAIN_CYCLES);
    collect(0, 1'b0, 4);

    // Backpressure: fragments straddle DRAIN/COLLECT while m_ready is low
    set_frags(5);
    feed(READ_LEN, 1'b1, -1, 0, READ_LEN + 2, 1);
    run_core(6, 1'b0, DRAIN_CYCLES);
    collect(6, 1'b1, 5);

    // Reset after 70 bases of the next read
    feed(70, 1'b0, -1, 0, -1, 1);
    check("busy_mid_read", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_read_reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    set_frags(6);
    feed(READ_LEN, 1'b1, -1, 0, READ_LEN + 2, 1);
    run_core(0, 1'b0, DRAIN_CYCLES);
    collect(0, 1'b0, 1);
    check("err_len_after_reset", err_len, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
